// File: rtl/demux_bank.sv
`default_nettype none
// ============================================================================
// demux_bank : routes one producer stream into 16 handshaked holding
//              registers, with a sequenced clear. Optional macro
//              DEMUX_BANK_BCAST_EN adds a broadcast-write input.
// Revision   : 1.0
// ============================================================================
module demux_bank #(
  parameter int W = 16,
  parameter int I = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [I-1:0] sel,
  input  logic [W-1:0] in_data,
  input  logic         clr,
  output logic         busy,
  input  logic [15:0]  ack,
`ifdef DEMUX_BANK_BCAST_EN
  input  logic         bcast,
`endif
  output logic [15:0]  out_valid,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic [W-1:0] out3,
  output logic [W-1:0] out4,
  output logic [W-1:0] out5,
  output logic [W-1:0] out6,
  output logic [W-1:0] out7,
  output logic [W-1:0] out8,
  output logic [W-1:0] out9,
  output logic [W-1:0] out10,
  output logic [W-1:0] out11,
  output logic [W-1:0] out12,
  output logic [W-1:0] out13,
  output logic [W-1:0] out14,
  output logic [W-1:0] out15
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    valid_q, valid_d;
  logic [W-1:0]   data_q [16];
  logic [W-1:0]   data_d [16];

  logic           bcast_en;
  logic [15:0]    chan_free;
  logic           xfer;
  logic [15:0]    wr_mask;

`ifdef DEMUX_BANK_BCAST_EN
  assign bcast_en = bcast;
`else
  assign bcast_en = 1'b0;
`endif

  // A held channel frees up in the same cycle its consumer acknowledges it.
  assign chan_free = ~valid_q | ack;
  assign in_ready  = (state_q == ST_IDLE) && !clr &&
                     (bcast_en ? (&chan_free) : chan_free[sel]);
  assign xfer      = in_valid && in_ready;
  assign wr_mask   = !xfer ? 16'h0000 : (bcast_en ? 16'hFFFF : (16'h0001 << sel));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q & ~ack;
    data_d  = data_q;

    for (int k = 0; k < 16; k++) begin
      if (wr_mask[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        data_d[cnt_q]  = '0;
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 16'h0000;
      for (int k = 0; k < 16; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign out_valid = valid_q;
  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out4      = data_q[4];
  assign out5      = data_q[5];
  assign out6      = data_q[6];
  assign out7      = data_q[7];
  assign out8      = data_q[8];
  assign out9      = data_q[9];
  assign out10     = data_q[10];
  assign out11     = data_q[11];
  assign out12     = data_q[12];
  assign out13     = data_q[13];
  assign out14     = data_q[14];
  assign out15     = data_q[15];

endmodule
`default_nettype wire

// File: tb/tb_demux_bank.sv
`default_nettype none
// ============================================================================
// tb_demux_bank : directed + randomized bench for demux_bank against a
//                 behavioural channel model.
// Revision      : 1.0
// ============================================================================
module tb_demux_bank;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [3:0]    sel;
  logic [W-1:0]  in_data;
  logic          clr;
  logic [15:0]   ack;
  logic          bcast;
  wire           in_ready;
  wire           busy;
  wire  [15:0]   out_valid;
  wire  [W-1:0]  dout [16];

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Behavioural model: channel contents plus number of clear steps remaining.
  logic [15:0]  m_valid = 16'h0000;
  logic [W-1:0] m_data [16];
  int           clr_left = 0;

  always #5 clk = ~clk;

  demux_bank #(.W(W), .I(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_data   (in_data),
    .clr       (clr),
    .busy      (busy),
    .ack       (ack),
`ifdef DEMUX_BANK_BCAST_EN
    .bcast     (bcast),
`endif
    .out_valid (out_valid),
    .out0      (dout[0]),
    .out1      (dout[1]),
    .out2      (dout[2]),
    .out3      (dout[3]),
    .out4      (dout[4]),
    .out5      (dout[5]),
    .out6      (dout[6]),
    .out7      (dout[7]),
    .out8      (dout[8]),
    .out9      (dout[9]),
    .out10     (dout[10]),
    .out11     (dout[11]),
    .out12     (dout[12]),
    .out13     (dout[13]),
    .out14     (dout[14]),
    .out15     (dout[15])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic bcast_on();
`ifdef DEMUX_BANK_BCAST_EN
    return bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_ready();
    logic [15:0] freev;
    freev = ~m_valid | ack;
    if (clr_left != 0 || clr) return 1'b0;
    if (bcast_on()) return (freev == 16'hFFFF);
    return freev[sel];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 16'h0000;
      clr_left = 0;
      for (int k = 0; k < 16; k++) m_data[k] = '0;
    end else begin
      logic wr;
      wr = in_valid && model_ready();
      m_valid = m_valid & ~ack;
      if (wr) begin
        for (int k = 0; k < 16; k++) begin
          if (bcast_on() || sel == k[3:0]) begin
            m_data[k]  = in_data;
            m_valid[k] = 1'b1;
          end
        end
      end
      if (clr_left != 0) begin
        m_data[16 - clr_left]  = '0;
        m_valid[16 - clr_left] = 1'b0;
        clr_left--;
      end else if (clr) begin
        clr_left = 16;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
      check("model_busy", {31'd0, busy}, {31'd0, (clr_left != 0)});
      check("model_out_valid", {16'd0, out_valid}, {16'd0, m_valid});
      for (int k = 0; k < 16; k++) begin
        check($sformatf("model_out%0d", k), {16'd0, dout[k]}, {16'd0, m_data[k]});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    sel      = 4'd0;
    in_data  = '0;
    clr      = 1'b0;
    ack      = 16'h0000;
    bcast    = 1'b0;
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    idle_inputs();
    repeat (2) next_cycle();
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {16'd0, out_valid}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single write to channel 3
    next_cycle();
    in_valid = 1'b1; sel = 4'd3; in_data = 16'hA5A5;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("wr3_out3", {16'd0, dout[3]}, 32'h0000A5A5);
    check("wr3_out_valid", {16'd0, out_valid}, 32'h00000008);
    check("wr3_out2", {16'd0, dout[2]}, 32'h0);

    // Channel 5 back-pressure and ack-through
    next_cycle();
    in_valid = 1'b1; sel = 4'd5; in_data = 16'h1111; ack = 16'h0008;
    next_cycle();
    ack = 16'h0000; in_data = 16'h2222;
    @(negedge clk);
    check("ch5_stall_in_ready", {31'd0, in_ready}, 32'd0);
    next_cycle();
    ack = 16'h0020;
    @(negedge clk);
    check("ch5_ackthru_in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("ch5_out5", {16'd0, dout[5]}, 32'h00002222);
    check("ch5_out_valid", {16'd0, out_valid}, 32'h00000020);

    // Fill all channels, then clear with a colliding write and a mid-clear pulse
    next_cycle();
    ack = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      ack = 16'h0000; in_valid = 1'b1; sel = k[3:0]; in_data = 16'(k * 16'h0101);
    end
    next_cycle();
    in_valid = 1'b1; sel = 4'd0; in_data = 16'hFFFF; clr = 1'b1;
    @(negedge clk);
    check("fill_out_valid", {16'd0, out_valid}, 32'h0000FFFF);
    check("fill_out15", {16'd0, dout[15]}, 32'h00000F0F);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      idle_inputs();
      clr = (c == 5);
      @(negedge clk);
      if (busy) nb++;
    end
    check("clr_busy_cycles", nb, 32'd16);
    check("clr_out_valid", {16'd0, out_valid}, 32'h0);
    check("clr_out0", {16'd0, dout[0]}, 32'h0);
    check("clr_out9", {16'd0, dout[9]}, 32'h0);

    // Reset in the middle of a clear
    next_cycle();
    in_valid = 1'b1; sel = 4'd14; in_data = 16'hBEEF;
    next_cycle();
    idle_inputs();
    clr = 1'b1;
    nb = 0;
    for (int c = 0; c < 40 && nb < 8; c++) begin
      next_cycle();
      clr = 1'b0;
      @(negedge clk);
      if (busy) nb++;
    end
    check("rst_busy_reached", nb, 32'd8);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {16'd0, out_valid}, 32'h0);
    check("rst_mid_out14", {16'd0, dout[14]}, 32'h0);

`ifdef DEMUX_BANK_BCAST_EN
    next_cycle();
    in_valid = 1'b1; sel = 4'd2; in_data = 16'h7777;
    next_cycle();
    sel = 4'd9; in_data = 16'h1234; bcast = 1'b1;
    @(negedge clk);
    check("bcast_stall", {31'd0, in_ready}, 32'd0);
    next_cycle();
    ack = 16'h0004;
    @(negedge clk);
    check("bcast_ackthru", {31'd0, in_ready}, 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("bcast_out_valid", {16'd0, out_valid}, 32'h0000FFFF);
    check("bcast_out7", {16'd0, dout[7]}, 32'h00001234);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      next_cycle();
      rst      = ($urandom_range(0, 299) == 0);
      clr      = ($urandom_range(0, 59) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      sel      = 4'($urandom);
      in_data  = 16'($urandom);
      ack      = 16'($urandom & $urandom & $urandom);
`ifdef DEMUX_BANK_BCAST_EN
      bcast    = ($urandom_range(0, 7) == 0);
`endif
    end
    next_cycle();
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/demux_bank.md
# demux_bank

Write-side counterpart of the 16-input `mux` used on the datapath. A single producer stream (`in_data` + `sel`) is routed into one of 16 holding registers, each with its own valid/ack handshake toward its consumer. A sequenced clear walks and zeroes all channels. The bank sits between the datapath result bus and the per-unit operand registers that the `mux` later reads back.

## Interface
- `w`, 16, data width of input and every channel register
- `i`, 4, select width; channel count is fixed at 16, so `i` must be 4
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer presents `in_data`/`sel`
- `in_ready`  out  1  bank accepts this cycle (combinational)
- `sel`  in  `i`  target channel index 0..15
- `in_data`  in  `w`  word to store
- `clr`  in  1  request sequenced clear of all channels
- `busy`  out  1  clear sequence in progress
- `ack`  in  16  per-channel consumer acknowledge; bit k consumes channel k
- `out_valid`  out  16  per-channel data-valid flags
- `out0` .. `out15`  out  `w` each  channel holding registers
- `bcast`  in  1  broadcast write; present only with `DEMUX_BANK_BCAST_EN`

## Operation
- FSM has two states:
  - IDLE: reset state.
  - CLEAR: entered when `clr`=1 in IDLE. Returns to IDLE after the last clear step.
- Channel k is free when `out_valid[k]`=0 or `ack[k]`=1 (ack-through).
- `in_ready` = (state==IDLE) && !`clr` && channel `sel` free.
- Transfer occurs when `in_valid` && `in_ready`:
  - Next edge: `out<sel>` <= `in_data` and `out_valid[sel]` <= 1.
  - If the same channel is acked in that cycle, the new data loads and valid stays 1.
- Ack:
  - `ack[k]` with `out_valid[k]`=1 and no write to k: `out_valid[k]` <= 0 next edge. `out<k>` keeps its value.
  - `ack[k]` with `out_valid[k]`=0 is ignored.
  - Acks on any number of channels are honoured in the same cycle.
- CLEAR:
  - A 4-bit counter starts at 0.
  - Each cycle: `out<cnt>` <= 0, `out_valid[cnt]` <= 0, cnt++.
  - After cnt=15 is cleared, the FSM returns to IDLE and cnt resets to 0.
  - `clr` asserted while in CLEAR is ignored; no restart.
  - `ack` remains effective during CLEAR.
- `clr` and `in_valid` in the same IDLE cycle: clear wins, no transfer (`in_ready`=0).
- `sel` is don't-care when `in_valid`=0.

## Timing
- Reset, synchronous:
  - All `out<k>` = 0, `out_valid` = 0, `busy` = 0, state IDLE, cnt 0.
  - After reset `in_ready` = 1 whenever `clr`=0.
- Write latency: 1 cycle from the accepting edge to `out_valid`/`out<k>` visible.
- Ack latency: valid drops 1 cycle after the acked edge.
- Clear:
  - `busy` rises the edge after `clr` is sampled and stays high exactly 16 cycles.
  - `in_ready` is 0 for the `clr` cycle plus the 16 busy cycles.
  - First write is accepted on the cycle `busy` returns to 0.
- `rst` during CLEAR aborts the sequence; all registers go to reset values immediately.
- `in_ready` depends combinationally on `ack`, `sel`, and `clr`. The producer must not make `in_valid` depend on `in_ready`.

## Configuration
- Macro: `DEMUX_BANK_BCAST_EN`
- Defined:
  - The `bcast` port exists.
  - With `bcast`=1, `in_ready` requires all 16 channels free (plus IDLE, !`clr`). `sel` is ignored.
  - A transfer writes `in_data` to every channel and sets `out_valid` = 16'hFFFF.
- Undefined:
  - No `bcast` port; unicast only.
  - Logic is identical to the defined case with `bcast` tied 0.

## Test plan
- Reset, then write `sel`=3, `in_data`=16'hA5A5 -> next cycle `out3`=A5A5, `out_valid`=16'h0008, other outputs 0.
- Write ch5 twice without ack -> second write sees `in_ready`=0. Assert `ack[5]` with the second write held -> `in_ready`=1, `out5` updates, `out_valid[5]` stays 1.
- Fill all 16 channels with values k*16'h0101, assert `clr` -> `busy` high 16 cycles. Channel k zeroed on busy cycle k+1. Final `out_valid`=0, all outputs 0.
- `clr` and `in_valid` (`sel`=0) in the same cycle -> no transfer, `out0` stays 0. `clr` pulsed again mid-CLEAR -> still exactly 16 busy cycles.
- `rst` asserted on busy cycle 8 -> next cycle `busy`=0, all outputs 0, `in_ready`=1.
- With `DEMUX_BANK_BCAST_EN`: `bcast`=1, `in_data`=16'h1234 with ch2 valid -> stalled until `ack[2]`. Then all `out<k>`=1234 and `out_valid`=16'hFFFF.
